// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - data-memory access sequencer between the MEM stage and byte-enabled data memory
module dm_access_ctrl #(
    parameter int WAIT_STATES = 0,
    parameter int DM_BYTES    = 4096
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic        AdEL,
    output logic        AdES,
    output logic [11:0] DmA,
    output logic [31:0] DmWD,
    output logic        DmWe,
    output logic [3:0]  DmBE,
    input  logic [31:0] DmRD
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ERR    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [11:0]   addr_q;
    logic [31:0]   sd_q;
    logic          err_q;

    logic          accept;
    logic          req_mis;
    logic          req_rng;
    logic          q_store;
    logic          last_cycle;
    logic [2:0]    req_size;
    logic [32:0]   req_limit;
    logic [31:0]   load_ext;
    logic [3:0]    be_q;

    always_comb begin
        case (Op)
            3'd0, 3'd1, 3'd5: req_size = 3'd1;
            3'd2, 3'd3, 3'd6: req_size = 3'd2;
            default:          req_size = 3'd4;
        endcase
    end

    assign req_mis    = (req_size == 3'd2 && Addr[0]) || (req_size == 3'd4 && Addr[1:0] != 2'b00);
    // 33-bit compare so addresses near 2^32 cannot wrap past the limit
    assign req_limit  = 33'(DM_BYTES) - {30'd0, req_size};
    assign req_rng    = {1'b0, Addr} > req_limit;
    assign accept     = Req && (state == S_IDLE || state == S_DONE);
    assign q_store    = op_q[2] & (op_q[1] | op_q[0]);
    assign last_cycle = (state == S_ACCESS) && (cnt == '0);

    always_comb begin
        case (op_q)
            3'd0:    load_ext = {{24{DmRD[7]}}, DmRD[7:0]};
            3'd1:    load_ext = {24'd0, DmRD[7:0]};
            3'd2:    load_ext = {{16{DmRD[15]}}, DmRD[15:0]};
            3'd3:    load_ext = {16'd0, DmRD[15:0]};
            default: load_ext = DmRD;
        endcase
    end

    always_comb begin
        case (op_q)
            3'd0, 3'd1, 3'd5: be_q = 4'b1000;
            3'd2, 3'd3, 3'd6: be_q = 4'b1100;
            default:          be_q = 4'b1111;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= 3'd0;
            addr_q   <= 12'd0;
            sd_q     <= 32'd0;
            err_q    <= 1'b0;
            LoadData <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q   <= Op;
                        addr_q <= Addr[11:0];
                        sd_q   <= StoreData;
                        err_q  <= req_mis || req_rng;
                        cnt    <= CW'(WAIT_STATES);
                        state  <= (req_mis || req_rng) ? S_ERR : S_ACCESS;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= S_DONE;
                        if (!q_store) LoadData <= load_ext;
                    end
                end
                default: state <= S_DONE;
            endcase
        end
    end

    // write enable is purely combinational so an async reset kills it at once
    assign Stall = accept || state == S_ACCESS || state == S_ERR;
    assign Done  = (state == S_DONE);
    assign AdEL  = Done && err_q && !q_store;
    assign AdES  = Done && err_q && q_store;
    assign DmA   = addr_q;
    assign DmWD  = sd_q;
    assign DmWe  = last_cycle && q_store;
    assign DmBE  = (state == S_ACCESS) ? be_q : 4'b0000;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - scoreboard bench for dm_access_ctrl with zero and three wait states
module tb_dm_access_ctrl;
    logic        Clk;
    int          cyc;
    int          total;
    int          bad;

    logic        rst0_n, req0, stall0, done0, adel0, ades0, dmwe0;
    logic [2:0]  op0;
    logic [31:0] addr0, sd0, ld0, dmwd0, dmrd0;
    logic [11:0] dma0;
    logic [3:0]  dmbe0;

    logic        rst1_n, req1, stall1, done1, adel1, ades1, dmwe1;
    logic [2:0]  op1;
    logic [31:0] addr1, sd1, ld1, dmwd1, dmrd1;
    logic [11:0] dma1;
    logic [3:0]  dmbe1;

    logic [7:0]  mem0 [4096];
    logic [7:0]  mem1 [4096];
    logic [7:0]  ref_mem [4096];
    logic [31:0] last_ld;

    typedef struct {
        int          cyc;
        logic [31:0] ld;
        logic        el;
        logic        es;
        int          we;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;
    exp_t sb [$];

    int we0_cnt;
    int we1_cnt;
    int done1_cnt;

    dm_access_ctrl #(.WAIT_STATES(0), .DM_BYTES(4096)) dut0 (
        .Clk(Clk), .Rst_n(rst0_n), .Req(req0), .Op(op0), .Addr(addr0), .StoreData(sd0),
        .Stall(stall0), .Done(done0), .LoadData(ld0), .AdEL(adel0), .AdES(ades0),
        .DmA(dma0), .DmWD(dmwd0), .DmWe(dmwe0), .DmBE(dmbe0), .DmRD(dmrd0)
    );

    dm_access_ctrl #(.WAIT_STATES(3), .DM_BYTES(4096)) dut1 (
        .Clk(Clk), .Rst_n(rst1_n), .Req(req1), .Op(op1), .Addr(addr1), .StoreData(sd1),
        .Stall(stall1), .Done(done1), .LoadData(ld1), .AdEL(adel1), .AdES(ades1),
        .DmA(dma1), .DmWD(dmwd1), .DmWe(dmwe1), .DmBE(dmbe1), .DmRD(dmrd1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    assign dmrd0 = {mem0[dma0 + 12'd3], mem0[dma0 + 12'd2], mem0[dma0 + 12'd1], mem0[dma0]};
    assign dmrd1 = {mem1[dma1 + 12'd3], mem1[dma1 + 12'd2], mem1[dma1 + 12'd1], mem1[dma1]};

    always @(posedge Clk) begin
        if (dmwe0) begin
            mem0[dma0] <= dmwd0[7:0];
            if (dmbe0[2]) mem0[dma0 + 12'd1] <= dmwd0[15:8];
            if (dmbe0[1]) begin
                mem0[dma0 + 12'd2] <= dmwd0[23:16];
                mem0[dma0 + 12'd3] <= dmwd0[31:24];
            end
        end
        if (dmwe1) begin
            mem1[dma1] <= dmwd1[7:0];
            if (dmbe1[2]) mem1[dma1 + 12'd1] <= dmwd1[15:8];
            if (dmbe1[1]) begin
                mem1[dma1 + 12'd2] <= dmwd1[23:16];
                mem1[dma1 + 12'd3] <= dmwd1[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (dmwe0) begin
            we0_cnt++;
            if (sb.size() > 0) begin
                chk("wr_be", {28'd0, dmbe0}, {28'd0, sb[0].be});
                chk("wr_wd", dmwd0, sb[0].wd);
            end
        end
        if (done0) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cyc", cyc, e.cyc);
                chk("load_data", ld0, e.ld);
                chk("adel", {31'd0, adel0}, {31'd0, e.el});
                chk("ades", {31'd0, ades0}, {31'd0, e.es});
                chk("we_cycles", we0_cnt, e.we);
            end
            we0_cnt = 0;
        end
        if (dmwe1) we1_cnt++;
        if (done1) done1_cnt++;
    end

    // reference byte memory decides the expected outcome of each request
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd);
        exp_t        e;
        int          size;
        bit          st;
        bit          err;
        logic [31:0] w;
        size = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 :
               (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 2 : 4;
        st   = (op >= 3'd5);
        err  = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00) ||
               ({32'd0, addr} > 64'(4096 - size));
        if (!err && st) begin
            for (int i = 0; i < size; i++) ref_mem[(addr + i) & 32'hFFF] = sd[8*i +: 8];
        end
        if (!err && !st) begin
            w = 32'd0;
            for (int i = 0; i < size; i++) w[8*i +: 8] = ref_mem[(addr + i) & 32'hFFF];
            if (op == 3'd0 && w[7])  w = w | 32'hFFFFFF00;
            if (op == 3'd2 && w[15]) w = w | 32'hFFFF0000;
            last_ld = w;
        end
        e.cyc = cyc + 2;
        e.ld  = last_ld;
        e.el  = err && !st;
        e.es  = err && st;
        e.we  = (!err && st) ? 1 : 0;
        e.be  = (size == 1) ? 4'b1000 : (size == 2) ? 4'b1100 : 4'b1111;
        e.wd  = sd;
        sb.push_back(e);
        req0  = 1'b1;
        op0   = op;
        addr0 = addr;
        sd0   = sd;
    endtask

    task automatic finish_wait();
        int n;
        @(posedge Clk) #2;
        req0  = 1'b0;
        op0   = 3'd0;
        addr0 = 32'hFFFF_FFFF;
        sd0   = 32'h0BAD_0BAD;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!done0 && n < 40);
        if (!done0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd);
        @(posedge Clk) #2;
        issue(op, addr, sd);
        finish_wait();
    endtask

    task automatic acc1(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd);
        int start;
        int n;
        @(posedge Clk) #2;
        start = cyc;
        req1 = 1'b1; op1 = op; addr1 = addr; sd1 = sd;
        @(posedge Clk) #2;
        req1 = 1'b0;
        n = 0;
        while (!done1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk("ws3_latency", cyc - start, 32'd5);
    endtask

    initial begin
        int start;
        int we_before;
        int done_before;
        total = 0; bad = 0; cyc = 0;
        we0_cnt = 0; we1_cnt = 0; done1_cnt = 0;
        last_ld = 32'd0;
        rst0_n = 1'b0; rst1_n = 1'b0;
        req0 = 1'b0; op0 = 3'd0; addr0 = 32'd0; sd0 = 32'd0;
        req1 = 1'b0; op1 = 3'd0; addr1 = 32'd0; sd1 = 32'd0;
        #12;
        chk("rst_stall", {31'd0, stall0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_err", {30'd0, adel0, ades0}, 32'd0);
        chk("rst_we_be", {27'd0, dmwe0, dmbe0}, 32'd0);
        chk("rst_dma", {20'd0, dma0}, 32'd0);
        chk("rst_dmwd", dmwd0, 32'd0);
        chk("rst_ld", ld0, 32'd0);
        @(posedge Clk) #2;
        rst0_n = 1'b1; rst1_n = 1'b1;

        access(3'd7, 32'h010, 32'h12345678);
        access(3'd4, 32'h010, 32'h0);
        access(3'd5, 32'h013, 32'hAABBCC80);
        access(3'd0, 32'h013, 32'h0);
        access(3'd1, 32'h013, 32'h0);
        access(3'd6, 32'h006, 32'h0000BEEF);
        access(3'd2, 32'h006, 32'h0);
        access(3'd3, 32'h006, 32'h0);
        access(3'd2, 32'h011, 32'h0);
        access(3'd7, 32'h002, 32'h11111111);
        access(3'd7, 32'h1000, 32'h22222222);
        access(3'd7, 32'hFFC, 32'hDEADBEEF);
        access(3'd4, 32'hFFC, 32'h0);
        access(3'd0, 32'hFFF, 32'h0);
        access(3'd2, 32'hFFF, 32'h0);
        access(3'd4, 32'h1000, 32'h0);
        access(3'd0, 32'hFFFF_FFFF, 32'h0);

        // back-to-back: second request lands in the first one's DONE cycle
        @(posedge Clk) #2;
        issue(3'd7, 32'h020, 32'h5A5AA5A5);
        @(posedge Clk) #2;
        @(posedge Clk) #2;
        issue(3'd4, 32'h020, 32'h0);
        finish_wait();
        @(posedge Clk) #2;
        chk("sb_drained", sb.size(), 32'd0);

        acc1(3'd7, 32'h040, 32'hCAFEF00D);
        @(posedge Clk) #2;
        req1 = 1'b1; op1 = 3'd4; addr1 = 32'h040; sd1 = 32'h0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge Clk);
            chk($sformatf("ws3_stall_c%0d", k), {31'd0, stall1}, (k < 5) ? 32'd1 : 32'd0);
            chk($sformatf("ws3_done_c%0d", k), {31'd0, done1}, (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) chk("ws3_load", ld1, 32'hCAFEF00D);
            @(posedge Clk) #2;
            req1 = 1'b0;
        end

        // reset pulse during the second ACCESS cycle of a store
        @(posedge Clk) #2;
        start = cyc;
        we_before = we1_cnt;
        done_before = done1_cnt;
        req1 = 1'b1; op1 = 3'd7; addr1 = 32'h040; sd1 = 32'h11111111;
        @(posedge Clk) #2;
        req1 = 1'b0;
        @(posedge Clk) #2;
        chk("rst_mid_cycle", cyc - start, 32'd2);
        rst1_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, dmwe1}, 32'd0);
        chk("mid_rst_flags", {28'd0, stall1, done1, adel1, ades1}, 32'd0);
        chk("mid_rst_be", {28'd0, dmbe1}, 32'd0);
        chk("mid_rst_dma", {20'd0, dma1}, 32'd0);
        chk("mid_rst_dmwd", dmwd1, 32'd0);
        chk("mid_rst_ld", ld1, 32'd0);
        #1;
        rst1_n = 1'b1;
        repeat (8) @(posedge Clk);
        #2;
        chk("mid_rst_no_write", we1_cnt - we_before, 32'd0);
        chk("mid_rst_no_done", done1_cnt - done_before, 32'd0);
        chk("mid_rst_mem", {mem1[12'h043], mem1[12'h042], mem1[12'h041], mem1[12'h040]}, 32'hCAFEF00D);
        acc1(3'd4, 32'h040, 32'h0);
        chk("post_rst_load", ld1, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
